// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse meter: state encoding, counter width and
// the command bundle the control unit sends to the data path.
package pulse_meter_pkg;

  localparam int         W   = 8;
  localparam logic [W-1:0] MAX = 8'd255;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ACK     = 3'd1;
  localparam logic [2:0] ST_ARM     = 3'd2;
  localparam logic [2:0] ST_WAIT_HI = 3'd3;
  localparam logic [2:0] ST_CNT     = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    ACK     = ST_ACK,
    ARM     = ST_ARM,
    WAIT_HI = ST_WAIT_HI,
    CNT     = ST_CNT
  } state_e;

  typedef struct packed {
    logic clr_eoc;
    logic load;
    logic inc;
    logic publish;
  } cmd_t;

endpackage

// File: rtl/pulse_meter_ctrl.sv
// Control unit: soc/eoc handshake and pulse-tracking FSM. Commands are decoded
// from the current state and sampled conditions so they act on the same edge
// as the transition.
module pulse_meter_ctrl
  import pulse_meter_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic soc,
  input  logic pulse_in,
  input  logic cnt_max,
  output cmd_t cmd
);

  state_e state_q;

  always_comb begin
    cmd = '0;
    case (state_q)
      IDLE:    cmd.clr_eoc = soc;
      WAIT_HI: cmd.load    = pulse_in;
      CNT: begin
        cmd.inc     = pulse_in && !cnt_max;
        cmd.publish = !pulse_in;
      end
      default: ;
    endcase
  end

  // soc is deliberately not looked at once the handshake has completed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (soc)       state_q <= ACK;
        ACK:     if (!soc)      state_q <= ARM;
        ARM:     if (!pulse_in) state_q <= WAIT_HI;
        WAIT_HI: if (pulse_in)  state_q <= CNT;
        CNT:     if (!pulse_in) state_q <= IDLE;
        default:                state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pulse_meter_datapath.sv
// Data path: pulse counter, published result and the eoc flag.
module pulse_meter_datapath
  import pulse_meter_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  cmd_t         cmd,
  output logic         cnt_max,
  output logic         eoc,
  output logic [W-1:0] numero
);

  logic [W-1:0] count;
  logic         eoc_q, eoc_d;
  logic [W-1:0] numero_q, numero_d;

  sat_counter #(.W(W), .MAX(MAX)) u_cnt (
    .clock  (clock),
    .reset  (reset),
    .load   (cmd.load),
    .inc    (cmd.inc),
    .q      (count),
    .at_max (cnt_max)
  );

  always_comb begin
    eoc_d    = eoc_q;
    numero_d = numero_q;
    if (cmd.clr_eoc) eoc_d = 1'b0;
    if (cmd.publish) begin
      eoc_d    = 1'b1;
      numero_d = count;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      eoc_q    <= 1'b1;
      numero_q <= '0;
    end else begin
      eoc_q    <= eoc_d;
      numero_q <= numero_d;
    end
  end

  assign eoc    = eoc_q;
  assign numero = numero_q;

endmodule

// File: rtl/pulse_meter_sat_counter.sv
// W-bit counter with load-to-one, increment and hold; sticks at MAX.
module sat_counter #(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         at_max
);

  logic [W-1:0] cnt_q, cnt_d;

  assign at_max = (cnt_q == MAX);
  assign q      = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = W'(1);
    else if (inc && !at_max)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pulse_meter.sv
// Measures the next complete high pulse on `in` after a soc/eoc handshake and
// publishes its length (saturating at 255) on numero.
module pulse_meter
  import pulse_meter_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         in,
  input  logic         soc,
  output logic         eoc,
  output logic [W-1:0] numero
);

  cmd_t cmd;
  logic cnt_max;

  pulse_meter_ctrl u_ctrl (
    .clock    (clock),
    .reset    (reset),
    .soc      (soc),
    .pulse_in (in),
    .cnt_max  (cnt_max),
    .cmd      (cmd)
  );

  pulse_meter_datapath u_dp (
    .clock   (clock),
    .reset   (reset),
    .cmd     (cmd),
    .cnt_max (cnt_max),
    .eoc     (eoc),
    .numero  (numero)
  );

endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter: directed scenarios plus random soc/in traffic, checked
// every cycle against a history-scanning reference model.
module tb_pulse_meter;

  logic       clock = 1'b0;
  logic       reset;
  logic       in;
  logic       soc;
  logic       eoc;
  logic [7:0] numero;

  always #5 clock = ~clock;

  pulse_meter dut (
    .clock  (clock),
    .reset  (reset),
    .in     (in),
    .soc    (soc),
    .eoc    (eoc),
    .numero (numero)
  );

  // Reference model: record every sampled (soc, in) since the last reset and
  // locate the milestones of each conversion in that history.
  bit         h_in[$];
  bit         h_soc[$];
  int         seg;
  logic       exp_eoc;
  logic [7:0] exp_num;

  function automatic int find_in(input int from, input bit v);
    for (int k = from; k < h_in.size(); k++)
      if (h_in[k] == v) return k;
    return -1;
  endfunction

  function automatic int find_soc(input int from, input bit v);
    for (int k = from; k < h_soc.size(); k++)
      if (h_soc[k] == v) return k;
    return -1;
  endfunction

  // t0: soc seen while idle; t1: soc dropped; t2: in low; t3: pulse start;
  // t4: pulse end, result published. Length = t4 - t3 edges, clamped at 255.
  function automatic void eval(input int s0, output int s_out, output logic e,
                               inout logic [7:0] num);
    int s;
    int t0, t1, t2, t3, t4;
    s = s0;
    e = 1'b1;
    for (int guard = 0; guard < 100000; guard++) begin
      t0 = find_soc(s, 1'b1);
      if (t0 < 0) begin e = 1'b1; break; end
      t1 = find_soc(t0 + 1, 1'b0);
      t2 = (t1 < 0) ? -1 : find_in(t1 + 1, 1'b0);
      t3 = (t2 < 0) ? -1 : find_in(t2 + 1, 1'b1);
      t4 = (t3 < 0) ? -1 : find_in(t3 + 1, 1'b0);
      if (t4 < 0) begin e = 1'b0; break; end
      num = (t4 - t3 > 255) ? 8'd255 : 8'(t4 - t3);
      s   = t4 + 1;
    end
    s_out = s;
  endfunction

  always @(posedge clock or posedge reset) begin
    int         s2;
    logic       e2;
    logic [7:0] nm;
    if (reset) begin
      h_in.delete();
      h_soc.delete();
      seg     <= 0;
      exp_eoc <= 1'b1;
      exp_num <= 8'd0;
    end else begin
      h_in.push_back(in);
      h_soc.push_back(soc);
      nm = exp_num;
      eval(seg, s2, e2, nm);
      seg     <= s2;
      exp_eoc <= e2;
      exp_num <= nm;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("eoc_vs_model", {31'd0, eoc}, {31'd0, exp_eoc});
    chk("numero_vs_model", {24'd0, numero}, {24'd0, exp_num});
  endtask

  // Drive one sample, let one rising edge take it, compare at the falling edge.
  task automatic cyc(input bit s, input bit i);
    soc = s;
    in  = i;
    @(negedge clock);
    cmp_model();
  endtask

  task automatic pulse(input int len);
    cyc(1'b0, 1'b0);
    repeat (len) cyc(1'b0, 1'b1);
    chk("busy_before_end", {31'd0, eoc}, 32'd0);
    cyc(1'b0, 1'b0);
  endtask

  task automatic async_reset_check(input string nm);
    #2 reset = 1'b1;
    #1;
    chk({nm, "_eoc"}, {31'd0, eoc}, 32'd1);
    chk({nm, "_num"}, {24'd0, numero}, 32'd0);
    @(negedge clock);
    cmp_model();
    reset = 1'b0;
  endtask

  initial begin
    bit cur_in;
    bit cur_soc;
    int run;

    reset = 1'b1;
    in    = 1'b0;
    soc   = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("reset_eoc", {31'd0, eoc}, 32'd1);
    chk("reset_num", {24'd0, numero}, 32'd0);
    reset = 1'b0;

    // idle with soc low: pulses on in are ignored
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0, k[0]);
      chk("idle_eoc", {31'd0, eoc}, 32'd1);
      chk("idle_num", {24'd0, numero}, 32'd0);
    end

    // basic 5-cycle measurement
    cyc(1'b1, 1'b0);
    chk("ack_eoc_low", {31'd0, eoc}, 32'd0);
    cyc(1'b0, 1'b0);
    pulse(5);
    chk("basic_eoc", {31'd0, eoc}, 32'd1);
    chk("basic_num", {24'd0, numero}, 32'd5);
    chk("model_basic_num", {24'd0, exp_num}, 32'd5);

    // pulse already high when soc falls is skipped; next 7-cycle pulse counts
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    repeat (10) cyc(1'b0, 1'b1);
    chk("prearm_busy", {31'd0, eoc}, 32'd0);
    pulse(7);
    chk("prearm_num", {24'd0, numero}, 32'd7);
    chk("model_prearm_num", {24'd0, exp_num}, 32'd7);

    // saturation
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    pulse(300);
    chk("sat_num", {24'd0, numero}, 32'd255);
    chk("model_sat_num", {24'd0, exp_num}, 32'd255);

    // reset during cycle 3 of a 10-cycle pulse
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b1);
    async_reset_check("midreset");
    repeat (6) cyc(1'b0, 1'b1);
    chk("post_reset_idle", {31'd0, eoc}, 32'd1);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    pulse(4);
    chk("post_reset_num", {24'd0, numero}, 32'd4);

    // back-to-back with soc held high through completion
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    chk("b2b_first_eoc", {31'd0, eoc}, 32'd1);
    chk("b2b_first_num", {24'd0, numero}, 32'd1);
    cyc(1'b1, 1'b0);
    chk("b2b_restart_eoc", {31'd0, eoc}, 32'd0);
    chk("b2b_hold_num", {24'd0, numero}, 32'd1);
    cyc(1'b0, 1'b0);
    pulse(2);
    chk("b2b_second_eoc", {31'd0, eoc}, 32'd1);
    chk("b2b_second_num", {24'd0, numero}, 32'd2);

    // random traffic, with occasional long pulses and asynchronous resets
    cur_in  = 1'b0;
    cur_soc = 1'b0;
    run     = 0;
    for (int c = 0; c < 4000; c++) begin
      if (run == 0) begin
        cur_in = ~cur_in;
        if ($urandom_range(0, 9) == 0) run = int'($urandom_range(50, 300));
        else                           run = int'($urandom_range(1, 8));
      end
      run--;
      if ($urandom_range(0, 5) == 0) cur_soc = ~cur_soc;
      if ($urandom_range(0, 599) == 0) begin
        soc = cur_soc;
        in  = cur_in;
        async_reset_check("rand_reset");
      end
      cyc(cur_soc, cur_in);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
